// File: rtl/controle_multiciclo_if.sv
// Bundle of opcode/status inputs and datapath control outputs
// for the nRISC multicycle control unit.
interface controle_multiciclo_if;
    logic [2:0] opcode;
    logic       zero;
    logic       mem_pronto;
    logic       pc_escreve;
    logic [1:0] pc_fonte;
    logic       ir_escreve;
    logic [1:0] ula_op;
    logic       mem_le;
    logic       mem_escreve;
    logic [1:0] sinalt2;
    logic       reg_escreve;
    logic       parado;
    logic [2:0] estado;

    modport master (
        input  opcode, zero, mem_pronto,
        output pc_escreve, pc_fonte, ir_escreve, ula_op,
        output mem_le, mem_escreve, sinalt2, reg_escreve,
        output parado, estado
    );

    modport slave (
        output opcode, zero, mem_pronto,
        input  pc_escreve, pc_fonte, ir_escreve, ula_op,
        input  mem_le, mem_escreve, sinalt2, reg_escreve,
        input  parado, estado
    );
endinterface

// File: rtl/controle_multiciclo.sv
// Multicycle control FSM for the nRISC datapath: sequences
// fetch/decode/execute/memory/write-back and drives all selects.
module controle_multiciclo (
    input  logic clock,
    input  logic reset,
    controle_multiciclo_if.master bus
);
    localparam logic [2:0] OCIOSO  = 3'd0;
    localparam logic [2:0] BUSCA   = 3'd1;
    localparam logic [2:0] DECOD   = 3'd2;
    localparam logic [2:0] EXEC    = 3'd3;
    localparam logic [2:0] MEM     = 3'd4;
    localparam logic [2:0] ESCRITA = 3'd5;
    localparam logic [2:0] PARADO  = 3'd6;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_LW   = 3'b010;
    localparam logic [2:0] OP_SW   = 3'b011;
    localparam logic [2:0] OP_JAL  = 3'b100;
    localparam logic [2:0] OP_BEQ  = 3'b101;
    localparam logic [2:0] OP_NOP  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    logic [2:0] r_estado;
    logic [2:0] w_prox;

    logic       w_pc_escreve;
    logic [1:0] w_pc_fonte;
    logic       w_ir_escreve;
    logic [1:0] w_ula_op;
    logic       w_mem_le;
    logic       w_mem_escreve;
    logic [1:0] w_sinalt2;
    logic       w_reg_escreve;
    logic       w_parado;

    always_ff @(posedge clock) begin
        if (reset)
            r_estado <= OCIOSO;
        else
            r_estado <= w_prox;
    end

    // Code 7 falls through to the default and recovers to OCIOSO.
    always_comb begin
        w_prox = OCIOSO;
        case (r_estado)
            OCIOSO: w_prox = BUSCA;
            BUSCA:  w_prox = DECOD;
            DECOD: begin
                case (bus.opcode)
                    OP_NOP:  w_prox = BUSCA;
                    OP_HALT: w_prox = PARADO;
                    default: w_prox = EXEC;
                endcase
            end
            EXEC: begin
                case (bus.opcode)
                    OP_LW, OP_SW: w_prox = MEM;
                    OP_BEQ:       w_prox = BUSCA;
                    default:      w_prox = ESCRITA;
                endcase
            end
            MEM: begin
                if (!bus.mem_pronto)
                    w_prox = MEM;
                else if (bus.opcode == OP_LW)
                    w_prox = ESCRITA;
                else
                    w_prox = BUSCA;
            end
            ESCRITA: w_prox = BUSCA;
            PARADO:  w_prox = PARADO;
            default: w_prox = OCIOSO;
        endcase
    end

    always_comb begin
        w_pc_escreve  = 1'b0;
        w_pc_fonte    = 2'b00;
        w_ir_escreve  = 1'b0;
        w_ula_op      = 2'b00;
        w_mem_le      = 1'b0;
        w_mem_escreve = 1'b0;
        w_sinalt2     = 2'b00;
        w_reg_escreve = 1'b0;
        w_parado      = 1'b0;
        case (r_estado)
            BUSCA: begin
                w_ir_escreve = 1'b1;
                w_pc_escreve = 1'b1;
            end
            EXEC: begin
                case (bus.opcode)
                    OP_SUB: w_ula_op = 2'b01;
                    OP_JAL: begin
                        w_pc_escreve = 1'b1;
                        w_pc_fonte   = 2'b01;
                    end
                    OP_BEQ: begin
                        w_ula_op     = 2'b10;
                        w_pc_escreve = bus.zero;
                        w_pc_fonte   = 2'b10;
                    end
                    default: w_ula_op = 2'b00;
                endcase
            end
            MEM: begin
                w_mem_le      = (bus.opcode == OP_LW);
                w_mem_escreve = (bus.opcode == OP_SW);
            end
            ESCRITA: begin
                w_reg_escreve = 1'b1;
                case (bus.opcode)
                    OP_LW:   w_sinalt2 = 2'b01;
                    OP_JAL:  w_sinalt2 = 2'b10;
                    default: w_sinalt2 = 2'b00;
                endcase
            end
            PARADO: w_parado = 1'b1;
            default: ;
        endcase
    end

    assign bus.pc_escreve  = w_pc_escreve;
    assign bus.pc_fonte    = w_pc_fonte;
    assign bus.ir_escreve  = w_ir_escreve;
    assign bus.ula_op      = w_ula_op;
    assign bus.mem_le      = w_mem_le;
    assign bus.mem_escreve = w_mem_escreve;
    assign bus.sinalt2     = w_sinalt2;
    assign bus.reg_escreve = w_reg_escreve;
    assign bus.parado      = w_parado;
    assign bus.estado      = r_estado;
endmodule
